// File: rtl/adc_pkg.sv
// Shared types and frame constants for the MCP3204 conversion sequencer.
package adc_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_e;

  localparam int unsigned FRAME_RISES     = 19;
  localparam int unsigned CMD_BITS        = 5;
  localparam int unsigned FIRST_DATA_RISE = 8;
  localparam int unsigned SAMPLE_BITS     = 12;

  // Command bit to present after `rise` rising edges have been issued; 0 once the
  // command {start, sgl_diff, D2, D1, D0} is exhausted.
  function automatic logic cmd_bit(logic [CMD_BITS-1:0] cmd, logic [4:0] rise);
    logic [2:0] idx;
    idx = 3'(CMD_BITS - 1) - rise[2:0];
    return (rise < 5'(CMD_BITS)) ? cmd[idx] : 1'b0;
  endfunction

endpackage

// File: rtl/adc_sclk_tick.sv
// Half-period timer: one-cycle tick every HALF cycles while enabled, cleared when idle.
module adc_sclk_tick #(
  parameter int unsigned HALF = 500
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned CntW = (HALF > 1) ? $clog2(HALF) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == CntW'(HALF - 1));

  // Count up while enabled, wrapping to 0 on each tick.
  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || tick_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/adc_frame_sampler.sv
// MCP3204 conversion frame sequencer: CS, SCLK, command on MOSI, 12-bit capture on MISO.
// The FSM and its internal SCLK/MOSI levels run one cycle ahead of the pins; every pin is a
// registered copy, so pin edges land one cycle after the internal events.
module adc_frame_sampler
  import adc_pkg::*;
#(
  parameter int unsigned HALF = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sgl_diff,
  input  logic [2:0]  channel,
  output logic        busy,
  output logic [11:0] sample,
  output logic        sample_valid,
  output logic        cs_n,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso
);

  state_e                 state_q, state_d;
  logic                   sclk_lvl_q, sclk_lvl_d;
  logic [4:0]             rise_q, rise_d;
  logic                   mosi_lvl_q, mosi_lvl_d;
  logic [CMD_BITS-1:0]    cmd_q, cmd_d;
  logic [SAMPLE_BITS-1:0] shift_q, shift_d;
  logic                   done_q, done_d;
  logic                   miso_s1_q, miso_s2_q;

  logic                   cs_n_q, sclk_q, mosi_q, busy_q, sample_valid_q;
  logic [SAMPLE_BITS-1:0] sample_q;

  logic                   tick, tick_en, in_frame;
  logic [4:0]             rise_inc;

  assign tick_en  = (state_q != IDLE);
  assign in_frame = (state_q == SETUP) || (state_q == SHIFT);
  assign rise_inc = rise_q + 5'd1;

  adc_sclk_tick #(
    .HALF(HALF)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .en_i  (tick_en),
    .tick_o(tick)
  );

  // Two-flop synchronizer for the asynchronous MISO line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miso_s1_q <= 1'b0;
      miso_s2_q <= 1'b0;
    end else begin
      miso_s1_q <= miso;
      miso_s2_q <= miso_s1_q;
    end
  end

  // FSM and internal frame state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sclk_lvl_q <= 1'b0;
      rise_q     <= '0;
      mosi_lvl_q <= 1'b0;
      cmd_q      <= '0;
      shift_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sclk_lvl_q <= sclk_lvl_d;
      rise_q     <= rise_d;
      mosi_lvl_q <= mosi_lvl_d;
      cmd_q      <= cmd_d;
      shift_q    <= shift_d;
      done_q     <= done_d;
    end
  end

  // Next-state: SCLK toggles on each tick; MOSI only moves on falling ticks.
  always_comb begin
    state_d    = state_q;
    sclk_lvl_d = sclk_lvl_q;
    rise_d     = rise_q;
    mosi_lvl_d = mosi_lvl_q;
    cmd_d      = cmd_q;
    shift_d    = shift_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        sclk_lvl_d = 1'b0;
        rise_d     = '0;
        mosi_lvl_d = 1'b0;
        if (start) begin
          cmd_d      = {1'b1, sgl_diff, channel};
          mosi_lvl_d = 1'b1;
          state_d    = SETUP;
        end
      end
      SETUP: begin
        if (tick) begin
          sclk_lvl_d = 1'b1;
          rise_d     = 5'd1;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (!sclk_lvl_q) begin
            sclk_lvl_d = 1'b1;
            rise_d     = rise_inc;
            if (rise_inc >= 5'(FIRST_DATA_RISE)) begin
              shift_d = {shift_q[SAMPLE_BITS-2:0], miso_s2_q};
            end
          end else begin
            sclk_lvl_d = 1'b0;
            if (rise_q == 5'(FRAME_RISES)) begin
              mosi_lvl_d = 1'b0;
              done_d     = 1'b1;
              state_d    = HOLD;
            end else begin
              mosi_lvl_d = cmd_bit(cmd_q, rise_q);
            end
          end
        end
      end
      HOLD: begin
        if (tick) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // Registered pin drivers and sample output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_n_q         <= 1'b1;
      sclk_q         <= 1'b0;
      mosi_q         <= 1'b0;
      busy_q         <= 1'b0;
      sample_valid_q <= 1'b0;
      sample_q       <= '0;
    end else begin
      cs_n_q         <= !in_frame;
      sclk_q         <= sclk_lvl_q;
      mosi_q         <= in_frame ? mosi_lvl_q : 1'b0;
      busy_q         <= (state_q != IDLE);
      sample_valid_q <= done_q;
      if (done_q) begin
        sample_q <= shift_q;
      end
    end
  end

  assign cs_n         = cs_n_q;
  assign sclk         = sclk_q;
  assign mosi         = mosi_q;
  assign busy         = busy_q;
  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;

endmodule

// File: tb/tb_adc_frame_sampler.sv
// Bench for adc_frame_sampler: MCP3204 behavioural model, vector table, random frames,
// reset abort, back-to-back frames, and a slow full-rate instance.
module tb_adc_frame_sampler;

  localparam int unsigned H = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sgl_diff = 1'b0;
  logic [2:0]  channel = 3'd0;
  logic        busy, sample_valid, cs_n, sclk, mosi;
  logic [11:0] sample;
  logic        miso = 1'b0;

  logic        start_s = 1'b0;
  logic        miso_s = 1'b0;
  logic        busy_s, sample_valid_s, cs_n_s, sclk_s, mosi_s;
  logic [11:0] sample_s;

  adc_frame_sampler #(.HALF(H)) dut (
    .clk(clk), .rst(rst), .start(start), .sgl_diff(sgl_diff), .channel(channel),
    .busy(busy), .sample(sample), .sample_valid(sample_valid), .cs_n(cs_n),
    .sclk(sclk), .mosi(mosi), .miso(miso)
  );

  adc_frame_sampler #(.HALF(500)) dut_slow (
    .clk(clk), .rst(rst), .start(start_s), .sgl_diff(1'b1), .channel(3'd0),
    .busy(busy_s), .sample(sample_s), .sample_valid(sample_valid_s), .cs_n(cs_n_s),
    .sclk(sclk_s), .mosi(mosi_s), .miso(miso_s)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // ADC model and pin monitor, evaluated just after each rising clk edge.
  int          ecount = 0;
  int          valid_count = 0, valid_edge = 0;
  int          busy_fall_edge = 0;
  int          csn_fall_count = 0, csn_fall_edge = 0;
  int          rises = 0, nxt = 0;
  int          mosi_bad = 0;
  logic [4:0]  mosi_cmd = 5'd0;
  logic [11:0] ch_val [16];
  logic        sclk_p = 1'b0, cs_n_p = 1'b1, busy_p = 1'b0, mosi_p = 1'b0;

  always @(posedge clk) begin
    ecount++;
    #1;
    if (sample_valid) begin
      valid_count++;
      valid_edge = ecount;
    end
    if (busy_p && !busy) busy_fall_edge = ecount;
    if (cs_n_p && !cs_n) begin
      csn_fall_count++;
      csn_fall_edge = ecount;
      mosi_cmd = 5'd0;
    end
    if (!cs_n_p && !cs_n && (mosi !== mosi_p) && !(sclk_p && !sclk)) mosi_bad++;
    if (cs_n) begin
      rises = 0;
      miso  = 1'b0;
    end else begin
      if (!sclk_p && sclk) begin
        rises++;
        if (rises <= 5) mosi_cmd[5 - rises] = mosi;
      end
      if (sclk_p && !sclk) begin
        nxt = rises + 1;
        if (nxt >= 8 && nxt <= 19) miso = ch_val[mosi_cmd[3:0]][19 - nxt];
        else miso = 1'b0;
      end
    end
    sclk_p = sclk;
    cs_n_p = cs_n;
    busy_p = busy;
    mosi_p = mosi;
  end

  typedef struct {
    logic        sgl;
    logic [2:0]  ch;
    logic [11:0] adc;
    bit          spam;
    bit          mut3;
    logic [4:0]  exp_cmd;
    logic [11:0] exp_sample;
  } vec_t;

  vec_t vecs[8];

  task automatic run_frame(input vec_t v);
    int vc, cf, acc, n;
    ch_val[{v.sgl, v.ch}] = v.adc;
    vc = valid_count;
    cf = csn_fall_count;
    @(negedge clk);
    sgl_diff = v.sgl;
    channel  = v.ch;
    start    = 1'b1;
    acc      = ecount + 1;
    @(negedge clk);
    if (!v.spam) start = 1'b0;
    if (!v.mut3) begin
      sgl_diff = 1'($urandom());
      channel  = 3'($urandom());
    end
    if (v.spam) begin
      repeat (130) begin
        @(negedge clk);
        start = 1'b1;
      end
      start = 1'b0;
    end
    if (v.mut3) begin
      n = 0;
      while (rises < 3 && n < 200) begin
        @(negedge clk);
        n++;
      end
      channel  = 3'd5;
      sgl_diff = !v.sgl;
    end
    n = 0;
    while (valid_count == vc && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("valid_pulses", valid_count - vc, 1);
    check("valid_cycle", valid_edge - acc, 1 + 38 * H);
    check("sample", int'(sample), int'(v.exp_sample));
    check("mosi_cmd", int'(mosi_cmd), int'(v.exp_cmd));
    n = 0;
    while (busy !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("busy_low_cycle", busy_fall_edge - acc, 1 + 39 * H);
    check("csn_fall_cycle", csn_fall_edge - acc, 1);
    repeat (6) @(negedge clk);
    check("frame_count", csn_fall_count - cf, 1);
  endtask

  initial begin
    int   n, vc, cf, acc, r1, r2;
    logic sp;
    vec_t rv;

    for (int i = 0; i < 16; i++) ch_val[i] = 12'h000;

    vecs[0] = '{1'b1, 3'd3, 12'hA5C, 1'b0, 1'b0, 5'b11011, 12'hA5C};
    vecs[1] = '{1'b1, 3'd3, 12'hA5C, 1'b1, 1'b0, 5'b11011, 12'hA5C};
    vecs[2] = '{1'b1, 3'd3, 12'h5A3, 1'b0, 1'b1, 5'b11011, 12'h5A3};
    vecs[3] = '{1'b1, 3'd0, 12'hFFF, 1'b0, 1'b0, 5'b11000, 12'hFFF};
    vecs[4] = '{1'b1, 3'd0, 12'h000, 1'b0, 1'b0, 5'b11000, 12'h000};
    vecs[5] = '{1'b0, 3'd6, 12'h123, 1'b0, 1'b0, 5'b10110, 12'h123};
    vecs[6] = '{1'b1, 3'd7, 12'h800, 1'b0, 1'b0, 5'b11111, 12'h800};
    vecs[7] = '{1'b0, 3'd1, 12'h001, 1'b0, 1'b0, 5'b10001, 12'h001};

    // Reset state.
    @(negedge clk);
    check("rst_cs_n", int'(cs_n), 1);
    check("rst_sclk", int'(sclk), 0);
    check("rst_mosi", int'(mosi), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_sample", int'(sample), 0);
    check("rst_sample_valid", int'(sample_valid), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Table-driven frames.
    for (int i = 0; i < 8; i++) run_frame(vecs[i]);

    // Random frames against the spec-level expectations.
    for (int i = 0; i < 10; i++) begin
      rv.sgl        = 1'($urandom());
      rv.ch         = 3'($urandom());
      rv.adc        = 12'($urandom());
      rv.spam       = 1'b0;
      rv.mut3       = 1'b0;
      rv.exp_cmd    = {1'b1, rv.sgl, rv.ch};
      rv.exp_sample = rv.adc;
      run_frame(rv);
    end

    // Start held high: second frame's CS fall one cycle after busy drops.
    ch_val[{1'b1, 3'd2}] = 12'h3C7;
    vc = valid_count;
    cf = csn_fall_count;
    @(negedge clk);
    sgl_diff = 1'b1;
    channel  = 3'd2;
    start    = 1'b1;
    acc      = ecount + 1;
    n = 0;
    while (csn_fall_count < cf + 2 && n < 400) begin
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check("b2b_second_csn_cycle", csn_fall_edge - acc, 1 + 39 * H + 1);
    n = 0;
    while (valid_count < vc + 2 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("b2b_valid_pulses", valid_count - vc, 2);
    check("b2b_sample", int'(sample), 12'h3C7);
    n = 0;
    while (busy !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    repeat (6) @(negedge clk);
    check("b2b_frame_count", csn_fall_count - cf, 2);

    // Reset in the middle of SHIFT at rise 10.
    ch_val[{1'b1, 3'd3}] = 12'hA5C;
    @(negedge clk);
    sgl_diff = 1'b1;
    channel  = 3'd3;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vc = valid_count;
    n = 0;
    while (rises < 10 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("abort_reached_rise10", rises, 10);
    rst = 1'b1;
    #1;
    check("abort_cs_n", int'(cs_n), 1);
    check("abort_sclk", int'(sclk), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_sample_valid", int'(sample_valid), 0);
    check("abort_sample", int'(sample), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    check("abort_no_partial", valid_count - vc, 0);
    run_frame(vecs[0]);

    check("mosi_only_on_sclk_fall", mosi_bad, 0);

    // Full-rate instance: 1000-cycle SCLK period, valid at cycle 19001.
    @(negedge clk);
    start_s = 1'b1;
    acc = ecount + 1;
    @(negedge clk);
    start_s = 1'b0;
    n  = 0;
    r1 = -1;
    r2 = -1;
    sp = 1'b0;
    while (!sample_valid_s && n < 25000) begin
      @(negedge clk);
      n++;
      if (sclk_s && !sp) begin
        if (r1 < 0) r1 = ecount;
        else if (r2 < 0) r2 = ecount;
      end
      sp = sclk_s;
    end
    check("slow_valid_cycle", ecount - acc, 1 + 38 * 500);
    check("slow_first_rise", r1 - acc, 1 + 500);
    check("slow_sclk_period", r2 - r1, 1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
